inst_sequencer: RTL and testbench

- Generates the 35-bit instruction word consumed by the accelerator core; the core only executes this word.
- Runs one complete tile pass: weight load from xMem into the array, activation stream, then output-FIFO drain into psum memory.
- Software starts it with a one-cycle pulse plus configuration; it reports busy/done.

---
 rtl/inst_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_inst_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// Tile-pass sequencer: emits the registered 35-bit instruction word that walks the core
// through weight load, activation stream and output drain into psum memory.
module inst_sequencer #(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned addr_bw = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   cfg_mode,
    input  logic                   cfg_acc,
    input  logic [addr_bw-1:0]     cfg_len,
    input  logic [addr_bw-1:0]     cfg_x_base,
    input  logic [addr_bw-1:0]     cfg_w_base,
    input  logic [addr_bw-1:0]     cfg_psum_base,
    input  logic                   ofifo_valid,
    output logic [2*addr_bw+12:0]  inst,
    output logic                   busy,
    output logic                   done
);

    // k must reach len (A_RD runs len+1 cycles), so it gets one extra bit.
    localparam int unsigned KW = addr_bw + 1;

    typedef struct packed {
        logic               mode;
        logic               acc;
        logic               p_cen;
        logic               p_wen;
        logic [addr_bw-1:0] p_addr;
        logic               x_cen;
        logic               x_wen;
        logic [addr_bw-1:0] x_addr;
        logic               ofifo_rd;
        logic               ififo_wr;
        logic               ififo_rd;
        logic               l0_rd;
        logic               l0_wr;
        logic               execute;
        logic               load;
    } inst_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_RD,
        S_W_LOAD,
        S_W_SETTLE,
        S_A_RD,
        S_A_EXE,
        S_DRAIN,
        S_O_WR,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [addr_bw-1:0] n_q, n_d;
    logic               mode_q, mode_d;
    logic               acc_q, acc_d;
    logic [addr_bw-1:0] len_q, len_d;
    logic [addr_bw-1:0] x_base_q, x_base_d;
    logic [addr_bw-1:0] w_base_q, w_base_d;
    logic [addr_bw-1:0] psum_base_q, psum_base_d;
    inst_t              inst_q, inst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr;

    function automatic inst_t idle_word(input logic m);
        inst_t w;
        w       = '0;
        w.mode  = m;
        w.p_cen = 1'b1;
        w.p_wen = 1'b1;
        w.x_cen = 1'b1;
        w.x_wen = 1'b1;
        return w;
    endfunction

    // Next state, counters and latched configuration.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q + KW'(1);
        n_d         = n_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        len_d       = len_q;
        x_base_d    = x_base_q;
        w_base_d    = w_base_q;
        psum_base_d = psum_base_q;
        wr          = 1'b0;
        case (state_q)
            S_IDLE: begin
                k_d = '0;
                n_d = '0;
                if (start && (cfg_len != '0)) begin
                    state_d     = S_W_RD;
                    mode_d      = cfg_mode;
                    acc_d       = cfg_acc;
                    len_d       = cfg_len;
                    x_base_d    = cfg_x_base;
                    w_base_d    = cfg_w_base;
                    psum_base_d = cfg_psum_base;
                end
            end
            S_W_RD: begin
                if (k_q == KW'(row)) begin
                    state_d = S_W_LOAD;
                    k_d     = '0;
                end
            end
            S_W_LOAD: begin
                if (k_q == KW'(col - 1)) begin
                    state_d = S_W_SETTLE;
                    k_d     = '0;
                end
            end
            S_W_SETTLE: begin
                if (k_q == KW'(row - 1)) begin
                    state_d = S_A_RD;
                    k_d     = '0;
                end
            end
            S_A_RD: begin
                if (k_q == {1'b0, len_q}) begin
                    state_d = S_A_EXE;
                    k_d     = '0;
                end
            end
            S_A_EXE: begin
                if (k_q == ({1'b0, len_q} - KW'(1))) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                end
            end
            S_DRAIN: begin
                k_d = '0;
                if (ofifo_valid) begin
                    state_d = S_O_WR;
                    wr      = 1'b1;
                end
            end
            S_O_WR: begin
                k_d = '0;
                if (n_q == len_q) begin
                    state_d = S_DONE;
                end else if (ofifo_valid) begin
                    wr = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase
        if (wr) begin
            n_d = n_q + addr_bw'(1);
        end
    end

    // Word for the upcoming cycle, built from the next state so inst can be a plain flop.
    always_comb begin
        inst_d = idle_word(mode_d);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        case (state_d)
            S_W_RD: begin
                if (k_d < KW'(row)) begin
                    inst_d.x_cen  = 1'b0;
                    inst_d.x_addr = w_base_d + addr_bw'(k_d);
                end
                inst_d.l0_wr = (k_d != '0);
            end
            S_W_LOAD: begin
                inst_d.l0_rd = 1'b1;
                inst_d.load  = 1'b1;
            end
            S_A_RD: begin
                if (k_d < {1'b0, len_d}) begin
                    inst_d.x_cen  = 1'b0;
                    inst_d.x_addr = x_base_d + addr_bw'(k_d);
                end
                inst_d.l0_wr = (k_d != '0);
            end
            S_A_EXE: begin
                inst_d.l0_rd   = 1'b1;
                inst_d.execute = 1'b1;
            end
            S_O_WR: begin
                if (wr) begin
                    inst_d.ofifo_rd = 1'b1;
                    inst_d.p_cen    = 1'b0;
                    inst_d.p_wen    = 1'b0;
                    inst_d.p_addr   = psum_base_d + n_q;
                    inst_d.acc      = acc_d;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            n_q         <= '0;
            mode_q      <= 1'b0;
            acc_q       <= 1'b0;
            len_q       <= '0;
            x_base_q    <= '0;
            w_base_q    <= '0;
            psum_base_q <= '0;
            inst_q      <= idle_word(1'b0);
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            x_base_q    <= x_base_d;
            w_base_q    <= w_base_d;
            psum_base_q <= psum_base_d;
            inst_q      <= inst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: per-cycle reference of each tile pass built from phase lengths,
// a table of directed passes with hand-derived totals, reset/ignored-start sequences, random passes.
module tb_inst_sequencer;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cfg_mode;
    logic          cfg_acc;
    logic [AW-1:0] cfg_len;
    logic [AW-1:0] cfg_x_base;
    logic [AW-1:0] cfg_w_base;
    logic [AW-1:0] cfg_psum_base;
    logic          ofifo_valid;
    logic [34:0]   inst;
    logic          busy;
    logic          done;

    int   checks = 0;
    int   errors = 0;
    logic mode_lat = 1'b0;

    inst_sequencer #(.row(ROW), .col(COL), .addr_bw(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode), .cfg_acc(cfg_acc),
        .cfg_len(cfg_len), .cfg_x_base(cfg_x_base), .cfg_w_base(cfg_w_base),
        .cfg_psum_base(cfg_psum_base), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          mode;
        logic          acc;
        logic [AW-1:0] len;
        logic [AW-1:0] xb;
        logic [AW-1:0] wb;
        logic [AW-1:0] pb;
        int            vmode;   // 0: valid always 1, 1: pattern after A_EXE, 2: random
        logic [7:0]    pat;
        bit            glitch;
        int            e_busy;
        int            e_rd;
        int            e_wr;
        int            e_lastx;
        int            e_lastp;
    } vec_t;

    function automatic logic [34:0] idle_w(input logic m);
        logic [34:0] w;
        w     = '0;
        w[34] = m;
        w[32] = 1'b1;
        w[31] = 1'b1;
        w[19] = 1'b1;
        w[18] = 1'b1;
        return w;
    endfunction

    task automatic chk(input string name, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, " inst"}, inst, idle_w(mode_lat));
        chk({name, " busy"}, 35'(busy), 35'(0));
        chk({name, " done"}, 35'(done), 35'(0));
    endtask

    // Starts from an idle cycle (posedge+1); returns at the cycle after DONE.
    task automatic run_pass(input vec_t v, output int busy_n, output int done_n,
                            output int rd_n, output int wr_n, output int last_x, output int last_p);
        int len, b1, b2, b3, b4, p, writes, budget, k;
        logic prevv, vv, ed;
        bit fin;
        logic [34:0] ew;
        len = int'(v.len);
        b1 = ROW + 1;
        b2 = b1 + COL;
        b3 = b2 + ROW;
        b4 = b3 + len + 1;
        p  = b4 + len;
        budget = p + 40 * len + 64;
        busy_n = 0; done_n = 0; rd_n = 0; wr_n = 0; last_x = -1; last_p = -1;
        writes = 0; prevv = 1'b0; fin = 1'b0;
        cfg_mode = v.mode; cfg_acc = v.acc; cfg_len = v.len;
        cfg_x_base = v.xb; cfg_w_base = v.wb; cfg_psum_base = v.pb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_mode = 1'($urandom); cfg_acc = 1'($urandom); cfg_len = AW'($urandom);
        cfg_x_base = AW'($urandom); cfg_w_base = AW'($urandom); cfg_psum_base = AW'($urandom);
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            ew = idle_w(v.mode);
            ed = 1'b0;
            if (cyc < b1) begin
                if (cyc < ROW) begin
                    ew[19] = 1'b0;
                    ew[17:7] = 11'(int'(v.wb) + cyc);
                end
                if (cyc >= 1) ew[2] = 1'b1;
            end else if (cyc < b2) begin
                ew[3] = 1'b1;
                ew[0] = 1'b1;
            end else if (cyc < b3) begin
            end else if (cyc < b4) begin
                k = cyc - b3;
                if (k < len) begin
                    ew[19] = 1'b0;
                    ew[17:7] = 11'(int'(v.xb) + k);
                end
                if (k >= 1) ew[2] = 1'b1;
            end else if (cyc < p) begin
                ew[3] = 1'b1;
                ew[1] = 1'b1;
            end else if (cyc == p) begin
            end else if (writes == len) begin
                ed = 1'b1;
                fin = 1'b1;
            end else if (prevv) begin
                ew[6] = 1'b1;
                ew[32] = 1'b0;
                ew[31] = 1'b0;
                ew[30:20] = 11'(int'(v.pb) + writes);
                ew[33] = v.acc;
                writes++;
            end
            chk($sformatf("inst c%0d", cyc), inst, ew);
            chk($sformatf("busy c%0d", cyc), 35'(busy), 35'(1));
            chk($sformatf("done c%0d", cyc), 35'(done), 35'(ed));
            if (busy) busy_n++;
            if (done) done_n++;
            if (!inst[19]) begin rd_n++; last_x = int'(inst[17:7]); end
            if (!inst[32]) begin wr_n++; last_p = int'(inst[30:20]); end
            case (v.vmode)
                0: vv = 1'b1;
                1: vv = (cyc >= p && cyc - p < 8) ? v.pat[cyc - p] : 1'b1;
                default: vv = ($urandom_range(0, 9) < 7);
            endcase
            ofifo_valid = vv;
            prevv = vv;
            start = (v.glitch && cyc == p - 3);
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL pass_timeout got no done within %0d cycles expected done", budget);
        end
        mode_lat = v.mode;
        check_idle("after_done");
    endtask

    task automatic ignored_start(input string name);
        cfg_len = '0;
        cfg_mode = ~mode_lat;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_idle(name);
            @(posedge clk); #1;
        end
    endtask

    vec_t tbl[5];
    vec_t rv;
    int   bn, dn, rn, wn, lx, lp;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 11'd36, 11'd64,   11'd0,    11'd0,    0, 8'h00,        1'b0, 136, 44, 36, 99, 35};
        tbl[1] = '{1'b0, 1'b0, 11'd4,  11'd2046, 11'd0,    11'd2047, 0, 8'h00,        1'b0, 40,  12, 4,  1,  2};
        tbl[2] = '{1'b0, 1'b0, 11'd4,  11'd0,    11'd0,    11'd0,    1, 8'b1110_1001, 1'b0, 43,  12, 4,  3,  3};
        tbl[3] = '{1'b1, 1'b1, 11'd5,  11'd10,   11'd2045, 11'd100,  0, 8'h00,        1'b1, 43,  13, 5,  14, 104};
        tbl[4] = '{1'b0, 1'b1, 11'd1,  11'd7,    11'd3,    11'd9,    0, 8'h00,        1'b0, 31,  9,  1,  7,  9};

        reset = 1'b0; start = 1'b0; cfg_mode = 1'b0; cfg_acc = 1'b0; cfg_len = '0;
        cfg_x_base = '0; cfg_w_base = '0; cfg_psum_base = '0; ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset inst", inst, 35'h1_800C_0000);
        check_idle("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("post_reset");

        ignored_start("len0_start");

        for (int i = 0; i < 5; i++) begin
            run_pass(tbl[i], bn, dn, rn, wn, lx, lp);
            chk($sformatf("v%0d busy_cycles", i), 35'(bn), 35'(tbl[i].e_busy));
            chk($sformatf("v%0d done_count", i), 35'(dn), 35'(1));
            chk($sformatf("v%0d xmem_reads", i), 35'(rn), 35'(tbl[i].e_rd));
            chk($sformatf("v%0d psum_writes", i), 35'(wn), 35'(tbl[i].e_wr));
            chk($sformatf("v%0d last_xaddr", i), 35'(lx), 35'(tbl[i].e_lastx));
            chk($sformatf("v%0d last_paddr", i), 35'(lp), 35'(tbl[i].e_lastp));
        end

        ignored_start("len0_after_pass");

        // Abort mid-A_EXE with an asynchronous reset; mode falls back to 0.
        cfg_mode = 1'b1; cfg_acc = 1'b1; cfg_len = 11'd10;
        cfg_x_base = 11'd20; cfg_w_base = 11'd30; cfg_psum_base = 11'd40;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (38) @(posedge clk);
        #1;
        chk("pre_reset execute", 35'(inst[1]), 35'(1));
        reset = 1'b0;
        #1;
        mode_lat = 1'b0;
        chk("abort inst", inst, 35'h1_800C_0000);
        check_idle("abort");
        repeat (2) @(posedge clk);
        #1;
        check_idle("abort_hold");
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("abort_release");
        run_pass(tbl[1], bn, dn, rn, wn, lx, lp);
        chk("resume busy_cycles", 35'(bn), 35'(tbl[1].e_busy));
        chk("resume done_count", 35'(dn), 35'(1));

        for (int i = 0; i < 6; i++) begin
            rv.mode = 1'($urandom); rv.acc = 1'($urandom);
            rv.len = AW'($urandom_range(1, 24));
            rv.xb = AW'($urandom_range(0, 2047)); rv.wb = AW'($urandom_range(0, 2047));
            rv.pb = AW'($urandom_range(0, 2047));
            rv.vmode = 2; rv.pat = 8'h00; rv.glitch = 1'($urandom);
            rv.e_busy = 0; rv.e_rd = 0; rv.e_wr = 0; rv.e_lastx = 0; rv.e_lastp = 0;
            run_pass(rv, bn, dn, rn, wn, lx, lp);
            chk($sformatf("r%0d done_count", i), 35'(dn), 35'(1));
            chk($sformatf("r%0d psum_writes", i), 35'(wn), 35'(rv.len));
            chk($sformatf("r%0d xmem_reads", i), 35'(rn), 35'(ROW + int'(rv.len)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
